tsc_seq_ctrl: RTL and testbench
===============================

Name: tsc_seq_ctrl

Overview:
- Sequential trigger-condition controller for the Trojan-trigger benchmark harness in the AES designs.
- Qualifies two raw condition inputs (r1, r2) as an ordered, time-windowed, held event before asserting a sticky trigger.
- Sits between the condition sources and any payload/trigger consumer.
- Arm/clear/window are driven by the test harness; state and fire count are exposed for verification observability.

Parameters:
WIN_W, 8, width of the runtime window value (max r1-to-r2 gap in cycles)
HOLD_CNT, 4, consecutive r2-high cycles required to fire (legal range 1..255)
CNT_W, 16, width of the saturating fire counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset; 0 = reset asserted
en  input  1  arm enable; level-sensitive
clear  input  1  synchronous clear of FSM, single-cycle pulse
r1  input  1  first condition
r2  input  1  second condition
window  input  WIN_W  max cycles allowed between r1 and r2; sampled on ARMED->WAIT_R2
trigger  output  1  registered, sticky; high only in FIRED
armed  output  1  registered; high in ARMED, WAIT_R2, HOLD
state_o  output  3  current FSM state encoding
fire_cnt  output  CNT_W  number of IDLE/ARMED/WAIT/HOLD->FIRED transitions, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE, trigger=0, armed=0, fire_cnt=0, internal win/hold counters=0. Reset mid-operation aborts immediately; no fire is recorded.
- States and encoding: IDLE=0, ARMED=1, WAIT_R2=2, HOLD=3, FIRED=4.
- Priority on each edge: rst > clear > en=0 > state transitions.
- clear=1: state->IDLE from any state; fire_cnt unchanged.
- en=0 in ARMED/WAIT_R2/HOLD: state->IDLE. In FIRED, en is ignored; only clear or rst leave FIRED.
- IDLE: en=1 -> ARMED.
- ARMED transitions:
  - r1&r2 -> HOLD with hold=1; if HOLD_CNT=1, go directly to FIRED.
  - r1 only -> WAIT_R2, win=0, latch window.
  - otherwise stay.
- WAIT_R2 transitions:
  - r2=1 -> HOLD with hold=1 (FIRED if HOLD_CNT=1). r1 need not remain high.
  - r2=0 and win==latched window -> ARMED (timeout). With window=0, r2 must arrive the cycle immediately after r1.
  - else win++.
- HOLD transitions:
  - r2=1 and hold+1==HOLD_CNT -> FIRED.
  - r2=1 otherwise -> hold++.
  - r2=0 -> ARMED; hold cleared.
- FIRED: trigger=1 from the first cycle after the transition edge. Stays until clear/rst.
- fire_cnt increments by 1 on each transition into FIRED. It holds at 2^CNT_W-1 (no wrap).
- Outputs are registers decoded from next-state; no combinational path from inputs to outputs.
- Latency, HOLD_CNT=4, from the r1 sample edge: r2 high from the next cycle gives trigger high after 4 edges (edge0 WAIT_R2, edge1 HOLD/1, edge2 2, edge3 3, edge4 FIRED).
- win and hold counters are WIN_W and 8 bits wide; neither can overflow under the legal ranges.

Decomposition:
- Shared package tsc_pkg holds:
  - state enum/localparams (IDLE..FIRED)
  - state width constant (3)
  - HOLD counter width (8)
- One sub-module is natural: tsc_sat_counter (parameter W; inputs clk, rst, inc; output count; saturates at all-ones). It is instantiated once for fire_cnt.

Test Plan:
- Reset/arm: rst=0 mid-HOLD, then release with en=1 -> all outputs 0, state_o=0; next edge state_o=1, armed=1.
- Nominal fire: window=3, HOLD_CNT=4, r1 pulse at t0, r2 high t1..t4 -> state_o 2,3,3,3,4. trigger=1 after t4 edge; fire_cnt=1.
- Timeout: window=2, r1 pulse, r2 held low -> WAIT_R2 for 3 cycles, then ARMED, trigger=0. Repeat with window=0 and r2 two cycles late -> no fire.
- Hold break: r2 high 3 cycles then low (HOLD_CNT=4) -> back to ARMED, fire_cnt unchanged. Follow with simultaneous r1&r2 for 4 cycles -> FIRED.
- Priority: clear and en=0 together in HOLD -> IDLE. In FIRED with en=0 -> trigger stays 1. Then clear -> trigger=0 next cycle, state_o=0.
- Saturation (CNT_W=2): fire/clear 5 times -> fire_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/tsc_pkg.sv
// Shared types and widths for the sequential trigger-condition controller.
package tsc_pkg;

    localparam int ST_W   = 3;
    localparam int HOLD_W = 8;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        WAIT_R2 = 3'd2,
        HOLD    = 3'd3,
        FIRED   = 3'd4
    } state_t;

endpackage

// File: rtl/tsc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module tsc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/tsc_seq_ctrl.sv
// Ordered, windowed, held r1->r2 qualifier producing a sticky trigger.
module tsc_seq_ctrl
    import tsc_pkg::*;
#(
    parameter int WIN_W    = 8,
    parameter int HOLD_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             r1,
    input  logic             r2,
    input  logic [WIN_W-1:0] window,
    output logic             trigger,
    output logic             armed,
    output logic [ST_W-1:0]  state_o,
    output logic [CNT_W-1:0] fire_cnt
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CNT);
    localparam logic FIRE_NOW = (HOLD_LIM == HOLD_W'(1));

    state_t              state, nxt;
    logic [WIN_W-1:0]    win, win_n;
    logic [WIN_W-1:0]    lat, lat_n;
    logic [HOLD_W-1:0]   hold, hold_n;
    logic [HOLD_W-1:0]   hold_inc;
    logic                fire;

    assign hold_inc = hold + HOLD_W'(1);

    always_comb begin
        nxt    = state;
        win_n  = win;
        lat_n  = lat;
        hold_n = hold;
        if (clear) begin
            nxt    = IDLE;
            hold_n = '0;
        end else if (!en && (state != FIRED)) begin
            nxt    = IDLE;
            hold_n = '0;
        end else begin
            unique case (state)
                IDLE: nxt = ARMED;
                ARMED: begin
                    if (r1 && r2) begin
                        nxt    = FIRE_NOW ? FIRED : HOLD;
                        hold_n = HOLD_W'(1);
                    end else if (r1) begin
                        nxt   = WAIT_R2;
                        win_n = '0;
                        lat_n = window;
                    end
                end
                WAIT_R2: begin
                    if (r2) begin
                        nxt    = FIRE_NOW ? FIRED : HOLD;
                        hold_n = HOLD_W'(1);
                    end else if (win == lat) begin
                        nxt = ARMED;
                    end else begin
                        win_n = win + WIN_W'(1);
                    end
                end
                HOLD: begin
                    if (r2 && (hold_inc == HOLD_LIM)) begin
                        nxt    = FIRED;
                        hold_n = hold_inc;
                    end else if (r2) begin
                        hold_n = hold_inc;
                    end else begin
                        nxt    = ARMED;
                        hold_n = '0;
                    end
                end
                FIRED:   nxt = FIRED;
                default: nxt = IDLE;
            endcase
        end
    end

    assign fire = (nxt == FIRED) && (state != FIRED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            win     <= '0;
            lat     <= '0;
            hold    <= '0;
            trigger <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= nxt;
            win     <= win_n;
            lat     <= lat_n;
            hold    <= hold_n;
            trigger <= (nxt == FIRED);
            armed   <= (nxt == ARMED) || (nxt == WAIT_R2) || (nxt == HOLD);
        end
    end

    assign state_o = state;

    tsc_sat_counter #(.W(CNT_W)) u_fire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fire),
        .count (fire_cnt)
    );

endmodule

// File: tb/tb_tsc_seq_ctrl.sv
// Scoreboard bench: driver queues hand-computed expectations, monitor checks them.
module tb_tsc_seq_ctrl;

    localparam int WIN_W = 8;
    localparam int CNT_W = 2;

    typedef struct {
        int         id;
        logic [2:0] st;
        logic [1:0] fc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en, clear, r1, r2;
    logic [WIN_W-1:0] window;
    logic             trigger, armed;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] fire_cnt;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         step_id = 0;
    logic [1:0] efc = 2'd0;

    tsc_seq_ctrl #(.WIN_W(WIN_W), .HOLD_CNT(4), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (clear),
        .r1       (r1),
        .r2       (r2),
        .window   (window),
        .trigger  (trigger),
        .armed    (armed),
        .state_o  (state_o),
        .fire_cnt (fire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d want %0d", nm, id, act, exp);
        end
    endtask

    // one cycle of stimulus plus the state expected after the next edge
    task automatic step(input logic e, input logic c, input logic a, input logic b,
                        input logic [WIN_W-1:0] w, input logic [2:0] st);
        exp_t x;
        @(negedge clk);
        en = e; clear = c; r1 = a; r2 = b; window = w;
        step_id++;
        x.id = step_id; x.st = st; x.fc = efc;
        q.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("state", x.id, int'(state_o), int'(x.st));
            chk("trigger", x.id, int'(trigger), int'(x.st == 3'd4));
            chk("armed", x.id, int'(armed), int'(x.st inside {3'd1, 3'd2, 3'd3}));
            chk("fire_cnt", x.id, int'(fire_cnt), int'(x.fc));
        end
    end

    task automatic fire4();
        step(1, 0, 1, 1, 8'd0, 3);
        step(1, 0, 1, 1, 8'd0, 3);
        step(1, 0, 1, 1, 8'd0, 3);
        efc = (efc == 2'd3) ? 2'd3 : efc + 2'd1;
        step(1, 0, 1, 1, 8'd0, 4);
    endtask

    initial begin
        rst = 1'b0; en = 0; clear = 0; r1 = 0; r2 = 0; window = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 0, int'(state_o), 0);
        chk("rst_trig", 0, int'(trigger), 0);
        chk("rst_cnt", 0, int'(fire_cnt), 0);
        rst = 1'b1;
        step(1, 0, 0, 0, 8'd0, 1);
        step(1, 0, 1, 1, 8'd0, 3);
        // async reset mid-HOLD
        @(negedge clk);
        rst = 1'b0; en = 1; r1 = 0; r2 = 0;
        #1;
        chk("midrst_state", 0, int'(state_o), 0);
        chk("midrst_armed", 0, int'(armed), 0);
        chk("midrst_cnt", 0, int'(fire_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0, 8'd0, 1);
        // nominal: window 3, r1 then r2 four cycles
        step(1, 0, 1, 0, 8'd3, 2);
        step(1, 0, 0, 1, 8'd0, 3);
        step(1, 0, 0, 1, 8'd0, 3);
        step(1, 0, 0, 1, 8'd0, 3);
        efc = 2'd1;
        step(1, 0, 0, 1, 8'd0, 4);
        step(1, 0, 0, 0, 8'd0, 4);
        step(0, 0, 0, 0, 8'd0, 4);
        step(1, 1, 0, 0, 8'd0, 0);
        step(1, 0, 0, 0, 8'd0, 1);
        // timeout with window 2
        step(1, 0, 1, 0, 8'd2, 2);
        step(1, 0, 0, 0, 8'd0, 2);
        step(1, 0, 0, 0, 8'd0, 2);
        step(1, 0, 0, 0, 8'd0, 1);
        // window 0, r2 two cycles late
        step(1, 0, 1, 0, 8'd0, 2);
        step(1, 0, 0, 0, 8'd0, 1);
        step(1, 0, 0, 1, 8'd0, 1);
        step(1, 0, 0, 0, 8'd0, 1);
        // hold break after three r2 cycles
        step(1, 0, 1, 0, 8'd3, 2);
        step(1, 0, 0, 1, 8'd0, 3);
        step(1, 0, 0, 1, 8'd0, 3);
        step(1, 0, 0, 1, 8'd0, 3);
        step(1, 0, 0, 0, 8'd0, 1);
        fire4();
        step(1, 1, 0, 0, 8'd0, 0);
        step(1, 0, 0, 0, 8'd0, 1);
        // clear together with en=0 in HOLD, then en=0 alone
        step(1, 0, 1, 1, 8'd0, 3);
        step(0, 1, 1, 1, 8'd0, 0);
        step(1, 0, 0, 0, 8'd0, 1);
        step(1, 0, 1, 1, 8'd0, 3);
        step(0, 0, 0, 1, 8'd0, 0);
        step(1, 0, 0, 0, 8'd0, 1);
        // third fire, en ignored in FIRED, clear drops trigger
        fire4();
        step(0, 0, 0, 0, 8'd0, 4);
        step(0, 1, 0, 0, 8'd0, 0);
        // saturation: fourth and fifth fire hold at 3
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 0, 8'd0, 1);
            fire4();
            step(1, 1, 0, 0, 8'd0, 0);
        end
        @(negedge clk);
        en = 0; clear = 0; r1 = 0; r2 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
